pacman_gfx_lookup_arbiter: RTL
==============================

// Module: pacman_gfx_lookup_arbiter
// PURPOSE
//  - Shares one combinational tile/sprite graphic lookup port (x,y -> pixels) among NUM_REQ requesters
//    (pacman, ghosts, maze renderer).
//  - Arbitrates round-robin, drives the lookup coordinates, registers the returned pixel colour and
//    hands it back to the winner with a one-cycle valid pulse.
//  - Sits between the per-object render FSMs and the graphic blocks, ahead of the VGA pixel mux.
// PARAMETERS
//  NUM_REQ           4  number of requesters (>=2)
//  REL_BITS          4  width of relative x/y coordinate within a tile
//  PIXEL_COLOR_BITS  8  colour width (RRRGGGBB)
// PORTS
//  clk         in   1                   system clock; all logic on rising edge
//  rst         in   1                   synchronous, active-high reset
//  req         in   NUM_REQ             level request, one bit per requester
//  req_x       in   NUM_REQ*REL_BITS    packed x coords; requester i at [i*REL_BITS +: REL_BITS]
//  req_y       in   NUM_REQ*REL_BITS    packed y coords, same packing
//  gnt         out  NUM_REQ             one-hot grant, high during LOOKUP only
//  gfx_x       out  REL_BITS            registered lookup x to graphic block
//  gfx_y       out  REL_BITS            registered lookup y to graphic block
//  gfx_pixels  in   PIXEL_COLOR_BITS    combinational pixel from graphic block for (gfx_x,gfx_y)
//  rsp_valid   out  NUM_REQ             one-hot, one-cycle pulse: rsp_pixels valid for that requester
//  rsp_pixels  out  PIXEL_COLOR_BITS    registered pixel colour
//  busy        out  1                   high whenever state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, gnt=0, rsp_valid=0, gfx_x=gfx_y=0, rsp_pixels=0, busy=0, last=NUM_REQ-1.
//  - FSM: IDLE -> LOOKUP -> RESPOND -> IDLE; one lookup every 3 cycles max.
//  - IDLE: if req!=0, pick winner w = first set bit searching last+1, last+2, ... (mod NUM_REQ);
//    latch gfx_x/gfx_y from w's coords, gnt<=onehot(w), last<=w, go LOOKUP.
//    If req==0: stay IDLE, all outputs hold (gfx_x/gfx_y keep last value).
//  - LOOKUP: gnt=onehot(w); rsp_pixels<=gfx_pixels; rsp_valid<=onehot(w); gnt<=0; go RESPOND.
//  - RESPOND: rsp_valid=onehot(w) for exactly this cycle; rsp_valid<=0; go IDLE.
//  - Latency: req seen in IDLE at cycle N -> gnt at N+1 -> rsp_valid/rsp_pixels at N+2.
//  - Requester rule: hold req and coords until rsp_valid; drop req on the edge ending the rsp_valid
//    cycle unless a new lookup is wanted. req still high in IDLE is a new request.
//  - Coords are sampled only in IDLE on the grant edge; later changes are ignored.
//  - req changes in LOOKUP/RESPOND are ignored; re-evaluated in IDLE.
//  - rsp_pixels holds its value after RESPOND until the next LOOKUP.
//  - Simultaneous requests: a single winner per round-robin order; losers wait, no loss.
//  - Reset mid-operation (any state): in-flight lookup is discarded, no rsp_valid is emitted,
//    all reset values apply on the next cycle.
//  - gnt and rsp_valid are never both nonzero in the same cycle; each is zero or one-hot.
// CONFIGURATION
//  - SPRITE_ARB_FIXED_PRIO_EN defined: fixed priority, lowest set req index wins; last is unused
//    (still reset). A continuous req0 starves others by design (pacman priority).
//  - Not defined (default): round-robin as above; no requester waits more than NUM_REQ grants.
// TESTING
//  1 rst=1 two cycles with req=4'b1111 -> gnt=0, rsp_valid=0, busy=0, gfx_x=gfx_y=0 throughout.
//  2 req=4'b0100, x2=5, y2=9, model gfx_pixels=8'h38 -> cyc+1: gnt=0100, gfx_x=5, gfx_y=9;
//    cyc+2: rsp_valid=0100, rsp_pixels=8'h38; busy=1 on cyc+1..+2; cyc+3: idle.
//  3 all four requesters re-request right after their rsp -> grant order 0,1,2,3,0;
//    lookups exactly 3 cycles apart.
//  4 after a grant to 2, req=4'b1011 -> next grants 3, then 0, then 1.
//  5 rst pulsed during LOOKUP of req1 -> no rsp_valid afterward; with req=1111 the next grant is 0.
//  6 with SPRITE_ARB_FIXED_PRIO_EN, req=1111 held -> every grant goes to 0; req=1110 -> grant 1.

Source files
------------

// File: rtl/pacman_gfx_lookup_arbiter.sv
// Shares one combinational graphic lookup port among NUM_REQ render requesters (IDLE->LOOKUP->RESPOND).
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module pacman_gfx_lookup_arbiter #(
  parameter int NUM_REQ          = 4,
  parameter int REL_BITS         = 4,
  parameter int PIXEL_COLOR_BITS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*REL_BITS-1:0]  req_x,
  input  logic [NUM_REQ*REL_BITS-1:0]  req_y,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [REL_BITS-1:0]          gfx_x,
  output logic [REL_BITS-1:0]          gfx_y,
  input  logic [PIXEL_COLOR_BITS-1:0]  gfx_pixels,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [PIXEL_COLOR_BITS-1:0]  rsp_pixels,
  output logic                         busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND} state_t;

  state_t                      state, state_n;
  logic [IW-1:0]               last, last_n, win;
  logic [NUM_REQ-1:0]          gnt_n, rsp_valid_n;
  logic [REL_BITS-1:0]         gfx_x_n, gfx_y_n;
  logic [PIXEL_COLOR_BITS-1:0] rsp_pixels_n;

  // Scan in reverse so the candidate closest to the search start is the last one written.
  always_comb begin
    win = '0;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (req[i]) win = IW'(i);
`else
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last) + k) % NUM_REQ;
      if (req[idx]) win = IW'(idx);
    end
`endif
  end

  always_comb begin
    state_n      = state;
    last_n       = last;
    gnt_n        = '0;
    rsp_valid_n  = '0;
    gfx_x_n      = gfx_x;
    gfx_y_n      = gfx_y;
    rsp_pixels_n = rsp_pixels;
    unique case (state)
      IDLE: if (|req) begin
        state_n    = LOOKUP;
        gnt_n[win] = 1'b1;
        last_n     = win;
        gfx_x_n    = req_x[win*REL_BITS +: REL_BITS];
        gfx_y_n    = req_y[win*REL_BITS +: REL_BITS];
      end
      LOOKUP: begin
        state_n      = RESPOND;
        rsp_pixels_n = gfx_pixels;
        rsp_valid_n  = gnt;
      end
      RESPOND: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last       <= IW'(NUM_REQ-1);
      gnt        <= '0;
      rsp_valid  <= '0;
      gfx_x      <= '0;
      gfx_y      <= '0;
      rsp_pixels <= '0;
    end else begin
      state      <= state_n;
      last       <= last_n;
      gnt        <= gnt_n;
      rsp_valid  <= rsp_valid_n;
      gfx_x      <= gfx_x_n;
      gfx_y      <= gfx_y_n;
      rsp_pixels <= rsp_pixels_n;
    end
  end

  assign busy = (state != IDLE);

endmodule
